// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC sequencer.
package npc_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] NPC_SEL_SEQ = 2'b00;
  localparam logic [1:0] NPC_SEL_OFS = 2'b01;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_REDIR = 1'b1
  } state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/npc_redir_buf.sv
// Holds a redirect target that arrived while a fetch was outstanding.
// A new load always overwrites the held target (newest redirect wins).
module npc_redir_buf
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            consume,
  output logic [XLEN-1:0] target_q,
  output logic            pending
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      target_q <= '0;
      pending  <= 1'b0;
    end else if (load) begin
      target_q <= target;
      pending  <= 1'b1;
    end else if (consume) begin
      pending  <= 1'b0;
    end
  end

endmodule

// File: rtl/npc_sequencer.sv
// Fetch PC register and next-PC sequencing (hold / PC+4 / EX redirect) for the 5-stage pipe.
// Optional trap redirect enabled by defining NPC_TRAP_EN.
module npc_sequencer
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       npc_sel,
  input  logic [XLEN-1:0]  pc_offset,
  input  logic             stall_if,
  input  logic             imem_ready,
`ifdef NPC_TRAP_EN
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vec,
  output logic             flush_exmem,
`endif
  output logic             imem_req,
  output logic [XLEN-1:0]  pc,
  output logic             if_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             sel_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_t          state;
  logic            sel_ofs;
  logic            sel_bad;
  logic            take;
  logic            cnt_inc;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] target_q;
  logic            pending;

  assign sel_ofs = (npc_sel == NPC_SEL_OFS);
  assign sel_bad = npc_sel[1];

`ifdef NPC_TRAP_EN
  assign take        = trap_req | sel_ofs;
  assign tgt         = trap_req ? trap_vec : pc_offset;
  assign cnt_inc     = sel_ofs & ~trap_req;
  assign flush_exmem = rstn & trap_req;
`else
  assign take    = sel_ofs;
  assign tgt     = pc_offset;
  assign cnt_inc = sel_ofs;
`endif

  // Combinational handshake/flush outputs are forced low while reset is asserted.
  assign imem_req   = rstn;
  assign if_valid   = rstn & (state == S_FETCH) & imem_ready & ~stall_if & ~take;
  assign flush_ifid = rstn & (take | ((state == S_REDIR) & imem_ready));
  assign flush_idex = rstn & take;

  npc_redir_buf u_redir_buf (
    .clk      (clk),
    .rstn     (rstn),
    .load     (take & ~imem_ready),
    .target   (word_align(tgt)),
    .consume  (imem_ready),
    .target_q (target_q),
    .pending  (pending)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc           <= RESET_PC;
      state        <= S_FETCH;
      sel_err      <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      if (sel_bad) sel_err <= 1'b1;
      if (cnt_inc && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + CNT_W'(1);

      if (take) begin
        // Redirect beats stall; with the fetch still outstanding, park the target.
        if (imem_ready) begin
          pc    <= word_align(tgt);
          state <= S_FETCH;
        end else begin
          state <= S_REDIR;
        end
      end else if (state == S_REDIR) begin
        if (imem_ready && pending) begin
          pc    <= target_q;
          state <= S_FETCH;
        end
      end else if (imem_ready && !stall_if) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed table-driven bench for npc_sequencer plus hand sequences for wrap, saturation and reset.
module tb_npc_sequencer;
  logic        clk;
  logic        rstn;
  logic [1:0]  npc_sel;
  logic [31:0] pc_offset;
  logic        stall_if;
  logic        imem_ready;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        flush_exmem;
  logic        imem_req;
  logic [31:0] pc;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        sel_err;
  logic [2:0]  redirect_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  npc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(3)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .npc_sel      (npc_sel),
    .pc_offset    (pc_offset),
    .stall_if     (stall_if),
    .imem_ready   (imem_ready),
`ifdef NPC_TRAP_EN
    .trap_req     (trap_req),
    .trap_vec     (trap_vec),
    .flush_exmem  (flush_exmem),
`endif
    .imem_req     (imem_req),
    .pc           (pc),
    .if_valid     (if_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .sel_err      (sel_err),
    .redirect_cnt (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ofs;
    logic        stall;
    logic        ready;
    logic [31:0] e_pc;
    logic        e_vld;
    logic        e_fi;
    logic        e_fe;
    logic        e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] s, input logic [31:0] o, input logic st, input logic rd);
    @(negedge clk);
    npc_sel    = s;
    pc_offset  = o;
    stall_if   = st;
    imem_ready = rd;
    trap_req   = 1'b0;
    #1;
  endtask

  initial begin
    //           sel    ofs           st    rd   | pc            vld   fi    fe    err   cnt
    tbl[0]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{2'd1, 32'h100,      1'b0, 1'b1, 32'h10,       1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[5]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[6]  = '{2'd1, 32'h200,      1'b0, 1'b0, 32'h104,      1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[7]  = '{2'd0, 32'h0,        1'b0, 1'b0, 32'h104,      1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[8]  = '{2'd0, 32'h0,        1'b0, 1'b0, 32'h104,      1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[9]  = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h104,      1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
    tbl[10] = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[11] = '{2'd0, 32'h0,        1'b1, 1'b1, 32'h204,      1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[12] = '{2'd1, 32'h303,      1'b1, 1'b1, 32'h204,      1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    tbl[13] = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tbl[14] = '{2'd3, 32'h0,        1'b0, 1'b1, 32'h304,      1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tbl[15] = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h308,      1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[16] = '{2'd1, 32'h400,      1'b0, 1'b0, 32'h30C,      1'b0, 1'b1, 1'b1, 1'b1, 3'd3};
    tbl[17] = '{2'd1, 32'h500,      1'b0, 1'b0, 32'h30C,      1'b0, 1'b1, 1'b1, 1'b1, 3'd4};
    tbl[18] = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h30C,      1'b0, 1'b1, 1'b0, 1'b1, 3'd5};
    tbl[19] = '{2'd0, 32'h0,        1'b0, 1'b1, 32'h500,      1'b1, 1'b0, 1'b0, 1'b1, 3'd5};
    tbl[20] = '{2'd0, 32'h0,        1'b0, 1'b0, 32'h504,      1'b0, 1'b0, 1'b0, 1'b1, 3'd5};
    tbl[21] = '{2'd2, 32'h0,        1'b0, 1'b0, 32'h504,      1'b0, 1'b0, 1'b0, 1'b1, 3'd5};

    // Reset with a redirect presented: everything must stay quiet.
    rstn = 1'b0; npc_sel = 2'd1; pc_offset = 32'h80; stall_if = 1'b0;
    imem_ready = 1'b1; trap_req = 1'b0; trap_vec = 32'h0;
    #12;
    chk("rst_pc",    pc,                 32'h0);
    chk("rst_req",   {31'b0, imem_req},  32'h0);
    chk("rst_vld",   {31'b0, if_valid},  32'h0);
    chk("rst_fi",    {31'b0, flush_ifid}, 32'h0);
    chk("rst_fe",    {31'b0, flush_idex}, 32'h0);
    chk("rst_err",   {31'b0, sel_err},   32'h0);
    chk("rst_cnt",   {29'b0, redirect_cnt}, 32'h0);

    @(negedge clk);
    npc_sel = 2'd0; imem_ready = 1'b0; rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].sel, tbl[i].ofs, tbl[i].stall, tbl[i].ready);
      chk($sformatf("v%0d_pc", i),  pc,                     tbl[i].e_pc);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req},      32'h1);
      chk($sformatf("v%0d_vld", i), {31'b0, if_valid},      {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_fi", i),  {31'b0, flush_ifid},    {31'b0, tbl[i].e_fi});
      chk($sformatf("v%0d_fe", i),  {31'b0, flush_idex},    {31'b0, tbl[i].e_fe});
      chk($sformatf("v%0d_err", i), {31'b0, sel_err},       {31'b0, tbl[i].e_err});
      chk($sformatf("v%0d_cnt", i), {29'b0, redirect_cnt},  {29'b0, tbl[i].e_cnt});
    end

    // PC wrap at the top of the address space and counter saturation.
    cyc(2'd1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    chk("wrap_fi", {31'b0, flush_ifid}, 32'h1);
    cyc(2'd1, 32'h40, 1'b0, 1'b1);
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    chk("sat_cnt6", {29'b0, redirect_cnt}, 32'h6);
    cyc(2'd1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    chk("sat_pc", pc, 32'h40);
    chk("sat_cnt7", {29'b0, redirect_cnt}, 32'h7);
    cyc(2'd0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc1", pc, 32'hFFFF_FFFC);
    chk("sat_hold", {29'b0, redirect_cnt}, 32'h7);
    chk("wrap_vld", {31'b0, if_valid}, 32'h1);
    cyc(2'd0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc2", pc, 32'h0);

    // Reset asserted while a redirect is parked.
    cyc(2'd1, 32'h600, 1'b0, 1'b0);
    chk("pre_rst_pc", pc, 32'h4);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pc",  pc,                   32'h0);
    chk("mid_rst_cnt", {29'b0, redirect_cnt}, 32'h0);
    chk("mid_rst_err", {31'b0, sel_err},     32'h0);
    chk("mid_rst_req", {31'b0, imem_req},    32'h0);
    chk("mid_rst_fi",  {31'b0, flush_ifid},  32'h0);
    @(negedge clk);
    rstn = 1'b1; npc_sel = 2'd0; imem_ready = 1'b1;
    #1;
    chk("post_rst_vld", {31'b0, if_valid},   32'h1);
    chk("post_rst_fi",  {31'b0, flush_ifid}, 32'h0);
    cyc(2'd0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_pc", pc, 32'h4);

`ifdef NPC_TRAP_EN
    @(negedge clk);
    npc_sel = 2'd1; pc_offset = 32'h700; trap_req = 1'b1; trap_vec = 32'h800;
    imem_ready = 1'b1; stall_if = 1'b0;
    #1;
    chk("trap_fx", {31'b0, flush_exmem}, 32'h1);
    chk("trap_fi", {31'b0, flush_ifid},  32'h1);
    cyc(2'd0, 32'h0, 1'b0, 1'b1);
    chk("trap_pc",  pc, 32'h800);
    chk("trap_cnt", {29'b0, redirect_cnt}, 32'h0);
    chk("trap_fx0", {31'b0, flush_exmem}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
